instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 100 ++++++++++
 tb/tb_instr_prefetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: fetches words from a combinational ROM into a small FIFO
// and presents them in order to decode, with redirect flush and synchronous reset.
module instr_prefetch #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  output logic [ADDR_WIDTH-1:0]   rom_address,
  input  logic [31:0]             rom_data,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [ADDR_WIDTH-1:0] PcOne   = 1;
  localparam logic [PtrW-1:0]       PtrOne  = 1;
  localparam logic [CntW-1:0]       CntOne  = 1;
  localparam logic [CntW-1:0]       CntFull = CntW'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic [31:0]           mem_instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc_q    [DEPTH];

  logic push, pop, full;

  assign rom_address = fetch_pc_q;
  assign count       = count_q;
  assign out_instr   = mem_instr_q[rd_ptr_q];
  assign out_pc      = mem_pc_q[rd_ptr_q];

  always_comb begin
    out_valid  = (count_q != '0) && !redirect;
    pop        = out_valid && out_ready;
    full       = (count_q == CntFull);
    // A full queue still accepts a new word when the head leaves in the same cycle.
    push       = enable && !redirect && (!full || pop);

    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PtrOne;
        fetch_pc_d = fetch_pc_q + PcOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push && !pop) begin
        count_d = count_q + CntOne;
      end else if (pop && !push) begin
        count_d = count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        mem_instr_q[wr_ptr_q] <= rom_data;
        mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed scenarios plus random traffic checked against a
// queue-based reference model of the fetch/deliver rules.
module tb_instr_prefetch;

  localparam int unsigned   AW       = 8;
  localparam int unsigned   DEPTH    = 4;
  localparam logic [AW-1:0] RESET_PC = 8'h00;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_data;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic [2:0]    count;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] m_fetch;
  logic [AW-1:0] m_pc[$];
  logic [31:0]   m_instr[$];
  logic [AW-1:0] delivered[$];

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  assign rom_data = rom_word(rom_address);

  instr_prefetch #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic rd,
                       input logic [AW-1:0] rpc, input logic rdy);
    reset       = r;
    enable      = en;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
  endtask

  // Check outputs mid-cycle against the model, then advance the model across the edge.
  task automatic tick();
    logic ev, pop_m, push_m;
    @(negedge clock);
    ev = (m_pc.size() != 0) && !redirect;
    chk("out_valid", {31'h0, out_valid}, {31'h0, ev});
    chk("rom_address", {24'h0, rom_address}, {24'h0, m_fetch});
    chk("count", {29'h0, count}, m_pc.size());
    if (ev) begin
      chk("out_pc", {24'h0, out_pc}, {24'h0, m_pc[0]});
      chk("out_instr", out_instr, m_instr[0]);
    end
    if (!reset) begin
      m_pc.delete();
      m_instr.delete();
      m_fetch = RESET_PC;
    end else if (redirect) begin
      m_pc.delete();
      m_instr.delete();
      m_fetch = redirect_pc;
    end else begin
      pop_m  = ev && out_ready;
      push_m = enable && ((m_pc.size() < DEPTH) || pop_m);
      if (pop_m) begin
        delivered.push_back(m_pc[0]);
        void'(m_pc.pop_front());
        void'(m_instr.pop_front());
      end
      if (push_m) begin
        m_pc.push_back(m_fetch);
        m_instr.push_back(rom_word(m_fetch));
        m_fetch = m_fetch + 8'h01;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    m_fetch = RESET_PC;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clock);
    #1;

    // Reset state
    tick();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", {24'h0, out_pc}, 32'h0);
    chk("rst_rom_address", {24'h0, rom_address}, {24'h0, RESET_PC});

    // Fill from reset with decode stalled
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    chk("fill1_valid", {31'h0, out_valid}, 32'h1);
    chk("fill1_count", {29'h0, count}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("fill_count", {29'h0, count}, 32'd4);
    chk("fill_rom_address", {24'h0, rom_address}, 32'h4);
    chk("fill_out_pc", {24'h0, out_pc}, 32'h0);
    chk("fill_out_instr", out_instr, 32'h1000_0000);

    // Full queue streaming: pop and push every cycle
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("stream_count", {29'h0, count}, 32'd4);
    chk("stream_rom_address", {24'h0, rom_address}, 32'h7);
    chk("stream_out_pc", {24'h0, out_pc}, 32'h3);

    // Redirect with three entries queued
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk("pre_redir_count", {29'h0, count}, 32'd3);
    drive(1'b1, 1'b1, 1'b1, 8'h40, 1'b1);
    #1;
    chk("redir_valid_low", {31'h0, out_valid}, 32'h0);
    tick();
    chk("redir_count", {29'h0, count}, 32'd0);
    chk("redir_rom_address", {24'h0, rom_address}, 32'h40);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    chk("redir_first_valid", {31'h0, out_valid}, 32'h1);
    chk("redir_first_pc", {24'h0, out_pc}, 32'h40);
    chk("redir_first_instr", out_instr, 32'h1000_0040);

    // Address wrap from 0xFE
    drive(1'b1, 1'b1, 1'b1, 8'hFE, 1'b1);
    tick();
    delivered.delete();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_n_delivered", delivered.size(), 32'd5);
    chk("wrap_pc0", {24'h0, delivered[0]}, 32'hFE);
    chk("wrap_pc1", {24'h0, delivered[1]}, 32'hFF);
    chk("wrap_pc2", {24'h0, delivered[2]}, 32'h00);
    chk("wrap_pc3", {24'h0, delivered[3]}, 32'h01);

    // Drain with fetch disabled
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    chk("drain_start_count", {29'h0, count}, 32'd2);
    delivered.delete();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("drain_n_delivered", delivered.size(), 32'd2);
    chk("drain_pc0", {24'h0, delivered[0]}, 32'h03);
    chk("drain_pc1", {24'h0, delivered[1]}, 32'h04);
    chk("drain_valid", {31'h0, out_valid}, 32'h0);
    chk("drain_rom_address", {24'h0, rom_address}, 32'h05);

    // Reset mid-fill overrides a concurrent redirect
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("midfill_count", {29'h0, count}, 32'd3);
    drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("rst_redir_count", {29'h0, count}, 32'd0);
    chk("rst_redir_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_redir_rom_address", {24'h0, rom_address}, {24'h0, RESET_PC});
    chk("rst_redir_out_pc", {24'h0, out_pc}, 32'h0);
    chk("rst_redir_out_instr", out_instr, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0, AW'($urandom), $urandom_range(0, 2) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
